// File: rtl/pe_acc.sv
// pe_acc: two-stage signed reduction of a LANES-wide product beat followed by a
// group accumulator. A group of beats is closed by in_last; the group sum and
// beat count are then offered downstream with a valid/ready handshake.
module pe_acc #(
    parameter int LANES  = 32,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*PROD_W-1:0]   mult_result,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [ACC_W-1:0]          acc_result,
    output logic [CNT_W-1:0]          acc_beats,
    output logic                      acc_valid,
    input  logic                      acc_ready
);

    localparam int QL = LANES / 4;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Sign-extend one lane product to accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    state_t                 state_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   in_ready_q;
    logic                   acc_valid_q;
    logic                   s1_valid_q;
    logic                   s1_last_q;
    logic                   s2_last_q;
    logic [ACC_W-1:0]       part_d [4];
    logic [ACC_W-1:0]       part_q [4];
    logic [ACC_W-1:0]       beat_sum_s;
    logic                   accept_s;

    assign accept_s   = in_valid & in_ready_q;
    assign in_ready   = in_ready_q;
    assign acc_valid  = acc_valid_q;
    assign acc_result = acc_q;
    assign acc_beats  = cnt_q;

    // Quarter-beat partial sums, each over LANES/4 sign-extended lanes.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            part_d[g] = '0;
            for (int l = 0; l < QL; l++) begin
                part_d[g] = part_d[g] + sext_prod(mult_result[PROD_W*(g*QL+l) +: PROD_W]);
            end
        end
    end

    // Stage 1: register the partials and the beat's valid/last tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int g = 0; g < 4; g++) part_q[g] <= '0;
        end else begin
            s1_valid_q <= accept_s;
            s1_last_q  <= accept_s & in_last;
            for (int g = 0; g < 4; g++) part_q[g] <= part_d[g];
        end
    end

    // Stage 2 next values: wrapping accumulate, saturating beat count.
    always_comb begin
        beat_sum_s = part_q[0] + part_q[1] + part_q[2] + part_q[3];
        acc_d      = acc_q + beat_sum_s;
        if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Group FSM with accumulator, beat count and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            s2_last_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            acc_valid_q <= 1'b0;
        end else begin
            // Marks that the closing beat has landed in acc this edge.
            s2_last_q <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
            case (state_q)
                ST_ACCUM: begin
                    if (accept_s && in_last) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (s2_last_q) begin
                        state_q     <= ST_DONE;
                        acc_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Pipe is empty here, so the clear cannot race an update.
                    if (acc_ready) begin
                        state_q     <= ST_ACCUM;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        acc_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_ACCUM;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    acc_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule
